mem_port_arbiter: RTL

- Shares the single SRAM-like memory port between the instruction-fetch requester (IFU) and the data requester (MEM stage load/store).
- Grants one address-phase request per cycle.
- Records the requester of every accepted request in an order FIFO, and routes each in-order data-phase response back to that requester.
- Sits between the pipeline stages and the memory bridge.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_order_fifo.sv | 71 +++++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter and its order FIFO.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  // Width of the outstanding counter; covers MAX_OUT up to 4.
  localparam int CNT_W  = 3;

  // Requester ids as stored in the order FIFO.
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // Address-phase request bundle, muxed as a unit onto the memory port.
  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_order_fifo.sv
// Order FIFO: remembers which requester owns each accepted, unanswered request.
module arb_order_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_src,
  input  logic             pop,
  output logic             head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] slot_q, slot_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = slot_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = push_src;
      wr_ptr_d         = next_ptr(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between IFU and MEM stage; routes in-order responses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  input  logic [STRB_W-1:0] inst_wstrb,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [STRB_W-1:0] data_wstrb,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  outstanding,
  output logic              proto_err
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  mem_req_t         inst_bundle, data_bundle, sel_bundle;
  logic             grant_src, grant_req, lock_hold, handshake, pop;
  logic             lock_valid_q, lock_valid_d;
  logic             lock_src_q, lock_src_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             proto_err_q, proto_err_d;
  logic             fifo_head, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;

  assign inst_bundle = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                         wdata: inst_wdata, wstrb: inst_wstrb};
  assign data_bundle = '{wr: data_wr, size: data_size, addr: data_addr,
                         wdata: data_wdata, wstrb: data_wstrb};

  // Arbitration: a held lock beats starvation override, which beats data priority.
  always_comb begin
    grant_src = SRC_INST;
    lock_hold = lock_valid_q & ((lock_src_q == SRC_DATA) ? data_req : inst_req);
    if (lock_hold)                                          grant_src = lock_src_q;
    else if (inst_req && starve_q == SC_W'(STARVE_LIMIT))   grant_src = SRC_INST;
    else if (data_req)                                      grant_src = SRC_DATA;
    else                                                    grant_src = SRC_INST;
    grant_req  = (grant_src == SRC_DATA) ? data_req : inst_req;
    sel_bundle = (grant_src == SRC_DATA) ? data_bundle : inst_bundle;
  end

  // Memory-port drive and per-requester handshakes; no bypass from a same-cycle pop.
  always_comb begin
    mem_req      = grant_req & ~fifo_full & ~reset;
    mem_wr       = sel_bundle.wr;
    mem_size     = sel_bundle.size;
    mem_addr     = sel_bundle.addr;
    mem_wdata    = sel_bundle.wdata;
    mem_wstrb    = sel_bundle.wstrb;
    handshake    = mem_req & mem_addr_ok;
    inst_addr_ok = handshake & (grant_src == SRC_INST);
    data_addr_ok = handshake & (grant_src == SRC_DATA);
    pop          = mem_data_ok & ~fifo_empty;
    inst_data_ok = pop & (fifo_head == SRC_INST);
    data_data_ok = pop & (fifo_head == SRC_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    outstanding  = fifo_count;
    proto_err    = proto_err_q;
  end

  // Next-state for lock, starvation counter and sticky protocol error.
  always_comb begin
    lock_valid_d = 1'b0;
    lock_src_d   = lock_src_q;
    starve_d     = starve_q;
    proto_err_d  = proto_err_q | (mem_data_ok & fifo_empty);
    // A stalled request pins the source so downstream sees a stable request.
    if (mem_req && !mem_addr_ok) begin
      lock_valid_d = 1'b1;
      lock_src_d   = grant_src;
    end
    if (!inst_req)
      starve_d = '0;
    else if (mem_req && grant_src == SRC_INST)
      starve_d = '0;
    else if (mem_req && grant_src == SRC_DATA && starve_q != SC_W'(STARVE_LIMIT))
      starve_d = starve_q + SC_W'(1);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_src_q   <= SRC_INST;
      starve_q     <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_src_q   <= lock_src_d;
      starve_q     <= starve_d;
      proto_err_q  <= proto_err_d;
    end
  end

  arb_order_fifo #(.DEPTH(MAX_OUT)) u_order_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (handshake),
    .push_src (grant_src),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule
